reg_file_dumper: RTL

//  Debug read-out engine for the RAT MCU register file. On a START pulse it walks the

---
 rtl/rat_dbg_pkg.sv | 13 +
 rtl/reg_file_dumper_if.sv | 22 ++
 rtl/reg_file_dumper.sv | 106 ++++++++++
 3 files changed

// File: rtl/rat_dbg_pkg.sv
// Shared types and defaults for the RAT MCU debug read-out blocks.
package rat_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_REG  = 2'd2,
        SEND_CSUM = 2'd3
    } dump_state_t;

    localparam logic [7:0] DUMP_HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/reg_file_dumper_if.sv
// Byte-stream VALID/READY link from the register-file dumper to a byte transmitter.
interface reg_file_dumper_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY;

    modport master (
        output TX_DATA,
        output TX_VALID,
        input  TX_READY
    );

    modport slave (
        input  TX_DATA,
        input  TX_VALID,
        output TX_READY
    );

endinterface

// File: rtl/reg_file_dumper.sv
// Walks the register file's Y read port and streams header, register bytes and an
// XOR checksum to a byte transmitter over a VALID/READY handshake.
module reg_file_dumper
    import rat_dbg_pkg::*;
#(
    parameter int                NUM_REGS  = 32,
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 8,
    parameter bit                HEADER_EN = 1'b1,
    parameter logic [DATA_W-1:0] HEADER    = DATA_W'(DUMP_HEADER_DEFAULT)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    output logic [ADDR_W-1:0]   RF_ADDR,
    input  logic [DATA_W-1:0]   RF_DATA,
    reg_file_dumper_if.master   tx,
    output logic                BUSY,
    output logic                DONE
);

    // One extra index bit so the "all registers sent" value fits when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] ONE_IDX  = (ADDR_W+1)'(1);

    dump_state_t       state_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [DATA_W-1:0] csum_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              done_reg;
    logic              handshake;

    assign handshake = valid_reg & tx.TX_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            csum_reg  <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        valid_reg <= 1'b1;
                        if (HEADER_EN) begin
                            data_reg  <= HEADER;
                            csum_reg  <= '0;
                            idx_reg   <= '0;
                            state_reg <= SEND_HDR;
                        end else begin
                            // idx is parked at 0 in IDLE, so RF_DATA already shows register 0.
                            data_reg  <= RF_DATA;
                            csum_reg  <= RF_DATA;
                            idx_reg   <= ONE_IDX;
                            state_reg <= SEND_REG;
                        end
                    end
                end
                SEND_HDR: begin
                    if (handshake) begin
                        data_reg  <= RF_DATA;
                        csum_reg  <= csum_reg ^ RF_DATA;
                        idx_reg   <= idx_reg + ONE_IDX;
                        state_reg <= SEND_REG;
                    end
                end
                SEND_REG: begin
                    if (handshake) begin
                        if (idx_reg < LAST_IDX) begin
                            data_reg <= RF_DATA;
                            csum_reg <= csum_reg ^ RF_DATA;
                            idx_reg  <= idx_reg + ONE_IDX;
                        end else begin
                            data_reg  <= csum_reg;
                            state_reg <= SEND_CSUM;
                        end
                    end
                end
                SEND_CSUM: begin
                    if (handshake) begin
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b1;
                        // Park the read port on register 0 for a header-less restart.
                        idx_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign RF_ADDR     = idx_reg[ADDR_W-1:0];
    assign BUSY        = (state_reg != IDLE);
    assign DONE        = done_reg;
    assign tx.TX_DATA  = data_reg;
    assign tx.TX_VALID = valid_reg;

endmodule
